// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 / double-dabble).
// Converts one input bit per clock. bcd holds the last result until the
// next conversion finishes. start/busy/done handshake, registered outputs.
// DIGITS must cover WIDTH (DIGITS >= ceil(WIDTH*log10(2))), otherwise the
// top digit silently wraps; there is no overflow flag.

// Per-digit correction cell: add 3 when the digit is 5 or more, so that the
// following left shift carries into the next decimal digit. Digits do not
// carry into each other here.
module bin2bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] bin_sr;
  logic [BW-1:0]   scratch;
  logic [BW-1:0]   scratch_adj;
  logic [BW-1:0]   scratch_nxt;
  logic [CW-1:0]   cnt;

  // Add-3 correction on every digit in parallel, top digit included.
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bin2bcd_add3 u_add3 (
        .d (scratch[4*g +: 4]),
        .q (scratch_adj[4*g +: 4])
      );
    end
  endgenerate

  // Shift the corrected scratch left; the operand MSB enters bit 0.
  assign scratch_nxt = (scratch_adj << 1) | BW'(bin_sr[WIDTH-1]);

  // Control FSM with registered busy/done; bcd only updates on the final shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bin_sr  <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            bin_sr  <= bin;
            scratch <= '0;
            cnt     <= CW'(WIDTH - 1);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bin_sr  <= bin_sr << 1;
          scratch <= scratch_nxt;
          cnt     <= cnt - 1'b1;
          if (cnt == '0) begin
            bcd   <= scratch_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // start is deliberately not looked at here
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
